// File: rtl/pd_pkg.sv
// Shared types for the packet-identifier stage and its consumers.
// One beat is 64 byte lanes of data plus a 3-bit type per lane.
package pd_pkg;

  localparam int PD_LANES  = 64;
  localparam int PD_BYTE_W = 8;
  localparam int PD_TYPE_W = 3;
  localparam int PD_DATA_W = PD_LANES * PD_BYTE_W;
  localparam int PD_BT_W   = PD_LANES * PD_TYPE_W;

  typedef struct packed {
    logic [PD_BT_W-1:0]   bytetype;
    logic [PD_DATA_W-1:0] data;
  } pd_beat_t;

  localparam int PD_BEAT_W = $bits(pd_beat_t);

endpackage

// File: rtl/pd_fifo_mem.sv
// Beat storage: simple dual-port RAM, DEPTH x pd_beat_t, sync write, async read.
// Zero read latency; no flow control here, the caller owns pointers and occupancy.
module pd_fifo_mem
  import pd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  pd_beat_t       wdat,
  input  logic [AW-1:0]  raddr,
  output pd_beat_t       rdat
);

  pd_beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/pd_out_fifo.sv
// Identifier output buffer, first-word-fall-through; beat visible 1 cycle after write.
// hld_pd asserts at level >= AFULL_THRESH; writes into a full FIFO without a pop are dropped.
module pd_out_fifo
  import pd_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PD_DATA_W-1:0]       data_in,
  input  logic [PD_BT_W-1:0]         bytetype_in,
  input  logic                       w,
  input  logic                       rd_en,
  output logic [PD_DATA_W-1:0]       data_out,
  output logic [PD_BT_W-1:0]         bytetype_out,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       hld_pd,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_THRESH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          full;
  logic          push;
  logic          pop;
  pd_beat_t      wr_beat;
  pd_beat_t      rd_beat;

  assign full  = (level_q == FULL_LVL);
  assign valid = (level_q != '0);
  assign pop   = rd_en & valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = w & (~full | pop);

  assign wr_beat.bytetype = bytetype_in;
  assign wr_beat.data     = data_in;

  pd_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wptr),
    .wdat  (wr_beat),
    .raddr (rptr),
    .rdat  (rd_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (w & full & ~pop) begin
        overflow_q <= 1'b1;
      end
      if (rd_en & ~valid) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign level        = level_q;
  assign hld_pd       = (level_q >= AFULL_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = valid ? rd_beat.data     : '0;
  assign bytetype_out = valid ? rd_beat.bytetype : '0;

endmodule
